// File: rtl/mult_div_divider_if.sv
// Operand/result bundle between the issuing pipeline stage and the divider.
// DIVIDER_DBZ_EN adds the divide-by-zero flag.
interface mult_div_divider_if;
  logic        start;
  logic [5:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef DIVIDER_DBZ_EN
  logic        dbz;
`endif

  modport master (
    output start, op, a, b,
`ifdef DIVIDER_DBZ_EN
    input  busy, done, hi, lo, dbz
`else
    input  busy, done, hi, lo
`endif
  );

  modport slave (
    input  start, op, a, b,
`ifdef DIVIDER_DBZ_EN
    output busy, done, hi, lo, dbz
`else
    output busy, done, hi, lo
`endif
  );
endinterface

// File: rtl/mult_div_divider.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU: quotient to lo, remainder to hi.
// DIVIDER_DBZ_EN: zero divisor short-circuits to DONE and raises dbz.
module mult_div_divider (
  input  logic               clk,
  input  logic               reset,
  mult_div_divider_if.slave  dif
);
  localparam logic [5:0] OP_DIV  = 6'b011010;
  localparam logic [5:0] OP_DIVU = 6'b011011;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t      state, state_n;
  logic [32:0] rem;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [4:0]  cnt;
  logic        neg_q, neg_r;
  logic [31:0] hi_q, lo_q;
  logic        dbz_q;

  logic        is_div, accept, dbz_hit;
  logic [31:0] a_abs, b_abs;
  logic [32:0] trial;
  logic [33:0] diff;
  logic        keep;
  logic        unused_rem_msb;

  assign is_div = (dif.op == OP_DIV);
  assign accept = (state == IDLE) && dif.start && (is_div || (dif.op == OP_DIVU));
`ifdef DIVIDER_DBZ_EN
  assign dbz_hit = accept && (dif.b == 32'd0);
`else
  assign dbz_hit = 1'b0;
`endif

  assign a_abs = (is_div && dif.a[31]) ? (32'd0 - dif.a) : dif.a;
  assign b_abs = (is_div && dif.b[31]) ? (32'd0 - dif.b) : dif.b;

  // Partial remainder never exceeds the divisor, so its top bit stays clear;
  // the extra subtract bit is what tells a genuine borrow from a large value.
  assign trial = {rem[31:0], dvd[31]};
  assign diff  = {1'b0, trial} - {2'b00, dvs};
  assign keep  = ~diff[33];
  assign unused_rem_msb = rem[32];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = dbz_hit ? DONE : RUN;
      RUN:  if (cnt == 5'd0) state_n = FIX;
      FIX:  state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
      dbz_q <= 1'b0;
    end else begin
      dbz_q <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          rem   <= '0;
          cnt   <= 5'd31;
          neg_q <= is_div && (dif.a[31] ^ dif.b[31]);
          neg_r <= is_div && dif.a[31];
          dvd   <= is_div ? a_abs : dif.a;
          dvs   <= is_div ? b_abs : dif.b;
          if (dbz_hit) begin
            hi_q  <= dif.a;
            lo_q  <= 32'hFFFF_FFFF;
            dbz_q <= 1'b1;
          end
        end
        RUN: begin
          rem <= keep ? diff[32:0] : trial;
          dvd <= {dvd[30:0], keep};
          cnt <= cnt - 5'd1;
        end
        FIX: begin
          lo_q <= neg_q ? (32'd0 - dvd) : dvd;
          hi_q <= neg_r ? (32'd0 - rem[31:0]) : rem[31:0];
        end
        default: ;
      endcase
    end
  end

  assign dif.busy = (state == RUN) || (state == FIX);
  assign dif.done = (state == DONE);
  assign dif.hi   = hi_q;
  assign dif.lo   = lo_q;
`ifdef DIVIDER_DBZ_EN
  assign dif.dbz  = dbz_q;
`endif
endmodule

// File: tb/tb_mult_div_divider.sv
// Randomized scoreboard bench for mult_div_divider against an arithmetic reference.
module tb_mult_div_divider;
  localparam logic [5:0] OP_DIV  = 6'b011010;
  localparam logic [5:0] OP_DIVU = 6'b011011;
  localparam logic [5:0] OP_ADD  = 6'b100000;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
    int          lat;
    int          t0;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [31:0] last_lo, last_hi, pend_lo, pend_hi;
  logic prev_done = 1'b0;

  mult_div_divider_if dif ();
  mult_div_divider dut (.clk(clk), .reset(reset), .dif(dif));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: quotient truncates toward zero, remainder takes dividend sign.
  function automatic void model(input logic [5:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] lo,
                                output logic [31:0] hi);
    longint sa, sb_;
    if (b == 32'd0) begin
      hi = a;
      lo = (op == OP_DIV && a[31]) ? 32'h1 : 32'hFFFF_FFFF;
    end else if (op == OP_DIVU) begin
      lo = a / b;
      hi = a % b;
    end else begin
      sa  = longint'($signed(a));
      sb_ = longint'($signed(b));
      lo = 32'(sa / sb_);
      hi = 32'(sa % sb_);
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && dif.done === 1'b1) begin
      chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("lo", dif.lo, e.lo);
        chk("hi", dif.hi, e.hi);
        chk("latency", 32'(cyc - e.t0), 32'(e.lat));
`ifdef DIVIDER_DBZ_EN
        chk("dbz", {31'd0, dif.dbz}, {31'd0, e.dbz});
`endif
      end
    end
`ifdef DIVIDER_DBZ_EN
    if (!reset && dif.done !== 1'b1 && dif.dbz !== 1'b0)
      chk("dbz_idle", {31'd0, dif.dbz}, 32'd0);
`endif
    prev_done = (dif.done === 1'b1);
  end

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(negedge clk);
    dif.start = 1'b1; dif.op = op; dif.a = a; dif.b = b;
    @(posedge clk);
    #1 dif.start = 1'b0;
    model(op, a, b, e.lo, e.hi);
    e.dbz = 1'b0;
    e.lat = 33;
`ifdef DIVIDER_DBZ_EN
    if (b == 32'd0) begin
      e.dbz = 1'b1;
      e.lat = 1;
      e.lo  = 32'hFFFF_FFFF;
      e.hi  = a;
    end
`endif
    e.t0 = cyc;
    pend_lo = e.lo; pend_hi = e.hi;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dif.done === 1'b1) begin seen = 1; break; end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=none required=done");
      sb.delete();
    end else begin
      chk("busy_at_done", {31'd0, dif.busy}, 32'd0);
      last_lo = pend_lo; last_hi = pend_hi;
    end
  endtask

  task automatic run(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    issue(op, a, b);
    wait_done();
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    sb.delete();
    last_lo = '0; last_hi = '0;
    @(negedge clk);
    chk("rst_busy", {31'd0, dif.busy}, 32'd0);
    chk("rst_done", {31'd0, dif.done}, 32'd0);
    chk("rst_hi", dif.hi, 32'd0);
    chk("rst_lo", dif.lo, 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [5:0]  rop;
    reset = 1'b1; dif.start = 1'b0; dif.op = '0; dif.a = '0; dif.b = '0;
    repeat (2) @(posedge clk);
    pulse_reset();

    run(OP_DIVU, 32'd100, 32'd7);
    @(negedge clk);
    chk("busy_after", {31'd0, dif.busy}, 32'd0);
    run(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    run(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
    run(OP_DIVU, 32'h1234_5678, 32'd0);
    run(OP_DIV, 32'h8765_4321, 32'd0);

    // A start while running must be dropped, not queued.
    issue(OP_DIVU, 32'd50, 32'd5);
    repeat (4) @(posedge clk);
    @(negedge clk);
    dif.start = 1'b1; dif.a = 32'd9; dif.b = 32'd3;
    @(posedge clk); #1 dif.start = 1'b0;
    @(negedge clk);
    chk("busy_midrun", {31'd0, dif.busy}, 32'd1);
    wait_done();

    // Non-divide op in IDLE leaves everything alone.
    repeat (2) @(negedge clk);
    dif.start = 1'b1; dif.op = OP_ADD; dif.a = 32'd11; dif.b = 32'd3;
    @(posedge clk); #1 dif.start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("add_busy", {31'd0, dif.busy}, 32'd0);
    end
    chk("add_hi_hold", dif.hi, last_hi);
    chk("add_lo_hold", dif.lo, last_lo);

    issue(OP_DIVU, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    pulse_reset();
    run(OP_DIVU, 32'd9, 32'd4);

    for (int n = 0; n < 24; n++) begin
      rop = ($urandom_range(0, 1) == 0) ? OP_DIV : OP_DIVU;
      ra  = $urandom();
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1, 2:    rb = $urandom_range(1, 20);
        3:       rb = -$urandom_range(1, 20);
        default: rb = $urandom();
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      run(rop, ra, rb);
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
